fetch_stage: RTL

//   PC register, next-PC select and IF/ID pipeline register. Sits directly downstream of the branch unit and consumes
//   its mux_to_pc / IF_Flush outputs. Runs the instruction-memory req/ready handshake and holds a 1-entry skid buffer
//   for words returned during a load-use stall.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select, instruction-memory req/ready handshake,
// a one-entry skid buffer for words returned under a load-use stall, and the IF/ID register.
module fetch_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mux_to_pc,
    input  logic            IF_Flush,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            kill_pend, kill_pend_nxt;
    logic [XLEN-1:0] pend_pc, pend_pc_nxt;
    logic [XLEN-1:0] skid_pc, skid_pc_nxt;
    logic [31:0]     skid_instr, skid_instr_nxt;
    logic [XLEN-1:0] ifid_pc_nxt;
    logic [31:0]     ifid_instr_nxt;
    logic            ifid_valid_nxt;

    logic            redirect;
    logic            transfer;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;

    assign redirect  = (mux_to_pc == 2'b01) || (mux_to_pc == 2'b10);
    assign target    = ((mux_to_pc == 2'b01) ? branch_target : jalr_target) & ALIGN_MASK;
    assign pc_plus4  = pc + PC_STEP;
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;
    assign transfer  = imem_req && imem_ready;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_nxt      = state;
        pc_nxt         = pc;
        kill_pend_nxt  = kill_pend;
        pend_pc_nxt    = pend_pc;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        ifid_pc_nxt    = ifid_pc;
        ifid_instr_nxt = ifid_instr;
        ifid_valid_nxt = ifid_valid;

        case (state)
            ST_BOOT: state_nxt = ST_REQ;
            ST_REQ: begin
                if (transfer && (redirect || kill_pend)) begin
                    // A redirect arriving with the transfer is newer than the pending one.
                    pc_nxt         = redirect ? target : pend_pc;
                    kill_pend_nxt  = 1'b0;
                    ifid_instr_nxt = NOP;
                    ifid_valid_nxt = 1'b0;
                end else if (transfer && stall) begin
                    skid_pc_nxt    = pc;
                    skid_instr_nxt = imem_rdata;
                    pc_nxt         = pc_plus4;
                    state_nxt      = ST_HOLD;
                end else if (transfer) begin
                    ifid_pc_nxt    = pc;
                    ifid_instr_nxt = imem_rdata;
                    ifid_valid_nxt = 1'b1;
                    pc_nxt         = pc_plus4;
                end else if (redirect) begin
                    // Address must stay put until the transfer; remember where to go afterwards.
                    kill_pend_nxt  = 1'b1;
                    pend_pc_nxt    = target;
                    ifid_instr_nxt = NOP;
                    ifid_valid_nxt = 1'b0;
                end else if (!stall) begin
                    ifid_instr_nxt = NOP;
                    ifid_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    skid_pc_nxt    = '0;
                    skid_instr_nxt = NOP;
                    pc_nxt         = target;
                    ifid_instr_nxt = NOP;
                    ifid_valid_nxt = 1'b0;
                    state_nxt      = ST_REQ;
                end else if (!stall) begin
                    ifid_pc_nxt    = skid_pc;
                    ifid_instr_nxt = skid_instr;
                    ifid_valid_nxt = 1'b1;
                    state_nxt      = ST_REQ;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase

        if (IF_Flush && !redirect) begin
            ifid_instr_nxt = NOP;
            ifid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            kill_pend  <= 1'b0;
            pend_pc    <= '0;
            skid_pc    <= '0;
            skid_instr <= NOP;
            ifid_pc    <= '0;
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state      <= state_nxt;
            pc         <= pc_nxt;
            kill_pend  <= kill_pend_nxt;
            pend_pc    <= pend_pc_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
            ifid_pc    <= ifid_pc_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_valid <= ifid_valid_nxt;
        end
    end

endmodule
